// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS-style CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC, PRId).
// Define CP0_TIMER_EN to build the Count/Compare timer; without it Count/Compare read 0.
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif

module cp0_regfile #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          CP0_ADDR_WIDTH = 5,
  parameter logic [31:0] PRID_VALUE     = 32'h0001_8000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cp0_reg_rw,
  input  logic [CP0_ADDR_WIDTH-1:0] cp0_reg_write_addr,
  input  logic [DATA_WIDTH-1:0]     cp0_reg_write,
  input  logic [CP0_ADDR_WIDTH-1:0] cp0_reg_read_addr,
  output logic [DATA_WIDTH-1:0]     cp0_reg_read,
  input  logic [5:0]                int_i,
  input  logic                      exc_valid,
  input  logic [4:0]                exc_code,
  input  logic [DATA_WIDTH-1:0]     exc_pc,
  input  logic                      exc_bd,
  input  logic [DATA_WIDTH-1:0]     exc_badvaddr,
  input  logic                      eret,
  output logic [DATA_WIDTH-1:0]     epc_out,
  output logic [DATA_WIDTH-1:0]     status_out,
  output logic [DATA_WIDTH-1:0]     cause_out,
  output logic                      timer_int,
  output logic                      int_pending
);

  localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_BADVADDR = CP0_ADDR_WIDTH'(5'd8);
  localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_COUNT    = CP0_ADDR_WIDTH'(5'd9);
  localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_COMPARE  = CP0_ADDR_WIDTH'(5'd11);
  localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_STATUS   = CP0_ADDR_WIDTH'(5'd12);
  localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_CAUSE    = CP0_ADDR_WIDTH'(5'd13);
  localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_EPC      = CP0_ADDR_WIDTH'(5'd14);
  localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_PRID     = CP0_ADDR_WIDTH'(5'd15);

  localparam logic [DATA_WIDTH-1:0] STATUS_WMASK = DATA_WIDTH'(32'h0000_FF03);
  localparam logic [DATA_WIDTH-1:0] CAUSE_WMASK  = DATA_WIDTH'(32'h0000_0300);
  localparam logic [DATA_WIDTH-1:0] STATUS_RESET = DATA_WIDTH'(32'h1000_0000);
  localparam logic [DATA_WIDTH-1:0] ZERO         = {DATA_WIDTH{1'b0}};

`ifdef CP0_TIMER_EN
  localparam logic TIMER_EN = 1'b1;
`else
  localparam logic TIMER_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;
  logic [DATA_WIDTH-1:0] epc_q, epc_d;
  logic [DATA_WIDTH-1:0] badvaddr_q, badvaddr_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] compare_q, compare_d;
  logic                  timer_int_q, timer_int_d;

  logic                  wr_s;
  logic                  wr_status_s, wr_cause_s, wr_epc_s, wr_count_s, wr_compare_s;
  logic                  exc_epc_upd_s;
  logic [DATA_WIDTH-1:0] status_sw_s;
  logic [DATA_WIDTH-1:0] cause_view_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  assign wr_s         = (cp0_reg_rw == `MEM_WRITE);
  assign wr_status_s  = wr_s && (cp0_reg_write_addr == ADDR_STATUS);
  assign wr_cause_s   = wr_s && (cp0_reg_write_addr == ADDR_CAUSE);
  assign wr_epc_s     = wr_s && (cp0_reg_write_addr == ADDR_EPC);
  assign wr_count_s   = wr_s && TIMER_EN && (cp0_reg_write_addr == ADDR_COUNT);
  assign wr_compare_s = wr_s && TIMER_EN && (cp0_reg_write_addr == ADDR_COMPARE);

  // A nested exception (EXL already set) must not disturb EPC or Cause.BD.
  assign exc_epc_upd_s = exc_valid && !status_q[1];

  assign status_sw_s  = wr_status_s ? ((status_q & ~STATUS_WMASK) | (cp0_reg_write & STATUS_WMASK))
                                    : status_q;
  assign cause_view_s = {cause_q[DATA_WIDTH-1:16], cause_q[15] | timer_int_q, cause_q[14:0]};

  // Next-state logic; per field: exception beats eret beats software write.
  always_comb begin
    status_d    = status_sw_s;
    status_d[1] = exc_valid ? 1'b1 : (eret ? 1'b0 : status_sw_s[1]);

    cause_d        = wr_cause_s ? ((cause_q & ~CAUSE_WMASK) | (cp0_reg_write & CAUSE_WMASK))
                                : cause_q;
    cause_d[15:10] = int_i;
    cause_d[6:2]   = exc_valid ? exc_code : cause_q[6:2];
    cause_d[31]    = exc_epc_upd_s ? exc_bd : cause_q[31];

    epc_d = exc_epc_upd_s ? (exc_bd ? (exc_pc - DATA_WIDTH'(32'd4)) : exc_pc)
                          : (wr_epc_s ? cp0_reg_write : epc_q);

    badvaddr_d = (exc_valid && ((exc_code == 5'd4) || (exc_code == 5'd5))) ? exc_badvaddr
                                                                           : badvaddr_q;
`ifdef CP0_TIMER_EN
    count_d     = wr_count_s ? cp0_reg_write : (count_q + DATA_WIDTH'(32'd1));
    compare_d   = wr_compare_s ? cp0_reg_write : compare_q;
    timer_int_d = wr_compare_s ? 1'b0
                               : (timer_int_q || ((count_q == compare_q) && (compare_q != ZERO)));
`else
    count_d     = ZERO;
    compare_d   = ZERO;
    timer_int_d = 1'b0;
`endif
  end

  // Read port with same-cycle write forwarding through each register's write mask.
  always_comb begin
    rdata_s = ZERO;
    case (cp0_reg_read_addr)
      ADDR_BADVADDR: rdata_s = badvaddr_q;
      ADDR_COUNT:    rdata_s = wr_count_s ? cp0_reg_write : count_q;
      ADDR_COMPARE:  rdata_s = wr_compare_s ? cp0_reg_write : compare_q;
      ADDR_STATUS:   rdata_s = status_sw_s;
      ADDR_CAUSE:    rdata_s = wr_cause_s ? ((cause_view_s & ~CAUSE_WMASK) | (cp0_reg_write & CAUSE_WMASK))
                                          : cause_view_s;
      ADDR_EPC:      rdata_s = wr_epc_s ? cp0_reg_write : epc_q;
      ADDR_PRID:     rdata_s = DATA_WIDTH'(PRID_VALUE);
      default:       rdata_s = ZERO;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q    <= STATUS_RESET;
      cause_q     <= ZERO;
      epc_q       <= ZERO;
      badvaddr_q  <= ZERO;
      count_q     <= ZERO;
      compare_q   <= ZERO;
      timer_int_q <= 1'b0;
    end else begin
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      badvaddr_q  <= badvaddr_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign cp0_reg_read = rdata_s;
  assign epc_out      = epc_q;
  assign status_out   = status_q;
  assign cause_out    = cause_view_s;
  assign timer_int    = timer_int_q;
  assign int_pending  = status_q[0] && !status_q[1] && (|(cause_view_s[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile; timer section follows CP0_TIMER_EN.
module tb_cp0_regfile;

  logic        clk;
  logic        rst_n;
  logic        cp0_reg_rw;
  logic [4:0]  cp0_reg_write_addr;
  logic [31:0] cp0_reg_write;
  logic [4:0]  cp0_reg_read_addr;
  logic [31:0] cp0_reg_read;
  logic [5:0]  int_i;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] epc_out;
  logic [31:0] status_out;
  logic [31:0] cause_out;
  logic        timer_int;
  logic        int_pending;

  int checks;
  int failures;

  cp0_regfile dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cp0_reg_rw         (cp0_reg_rw),
    .cp0_reg_write_addr (cp0_reg_write_addr),
    .cp0_reg_write      (cp0_reg_write),
    .cp0_reg_read_addr  (cp0_reg_read_addr),
    .cp0_reg_read       (cp0_reg_read),
    .int_i              (int_i),
    .exc_valid          (exc_valid),
    .exc_code           (exc_code),
    .exc_pc             (exc_pc),
    .exc_bd             (exc_bd),
    .exc_badvaddr       (exc_badvaddr),
    .eret               (eret),
    .epc_out            (epc_out),
    .status_out         (status_out),
    .cause_out          (cause_out),
    .timer_int          (timer_int),
    .int_pending        (int_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    cp0_reg_rw         = 1'b1;
    cp0_reg_write_addr = addr;
    cp0_reg_write      = data;
    tick();
    cp0_reg_rw = 1'b0;
    #1;
  endtask

  initial begin
    logic found;
    checks = 0; failures = 0;
    rst_n = 1'b0; cp0_reg_rw = 1'b0; cp0_reg_write_addr = 5'd0; cp0_reg_write = 32'd0;
    cp0_reg_read_addr = 5'd0; int_i = 6'd0; exc_valid = 1'b0; exc_code = 5'd0;
    exc_pc = 32'd0; exc_bd = 1'b0; exc_badvaddr = 32'd0; eret = 1'b0;

    // reset state
    #12;
    check("rst_status", status_out, 32'h1000_0000);
    check("rst_cause", cause_out, 32'h0000_0000);
    check("rst_epc", epc_out, 32'h0000_0000);
    check("rst_intp", {31'd0, int_pending}, 32'd0);
    check("rst_timer", {31'd0, timer_int}, 32'd0);
    cp0_reg_read_addr = 5'd15; #1;
    check("prid", cp0_reg_read, 32'h0001_8000);
    rst_n = 1'b1;
    tick();

    // Status write mask and forwarding
    cp0_reg_rw = 1'b1; cp0_reg_write_addr = 5'd12; cp0_reg_write = 32'hFFFF_FFFF;
    cp0_reg_read_addr = 5'd12; #1;
    check("status_fwd", cp0_reg_read, 32'h1000_FF03);
    check("status_out_unfwd", status_out, 32'h1000_0000);
    tick(); cp0_reg_rw = 1'b0; #1;
    check("status_rd", cp0_reg_read, 32'h1000_FF03);
    check("status_out", status_out, 32'h1000_FF03);
    check("intp_exl_block", {31'd0, int_pending}, 32'd0);

    // Cause write mask
    cp0_reg_rw = 1'b1; cp0_reg_write_addr = 5'd13; cp0_reg_write = 32'hFFFF_FFFF;
    cp0_reg_read_addr = 5'd13; #1;
    check("cause_fwd", cp0_reg_read, 32'h0000_0300);
    tick(); cp0_reg_rw = 1'b0; #1;
    check("cause_out_mask", cause_out, 32'h0000_0300);

    // unimplemented / read-only addresses
    cp0_reg_read_addr = 5'd3; do_write(5'd3, 32'h5555_5555);
    check("unimpl_rd", cp0_reg_read, 32'h0000_0000);
    cp0_reg_read_addr = 5'd15; do_write(5'd15, 32'h0000_0000);
    check("prid_ro", cp0_reg_read, 32'h0001_8000);
    cp0_reg_read_addr = 5'd8; do_write(5'd8, 32'h0000_FFFF);
    check("badv_ro", cp0_reg_read, 32'h0000_0000);
    do_write(5'd12, 32'h0000_0000);
    do_write(5'd13, 32'h0000_0000);
    check("status_clr", status_out, 32'h1000_0000);

    // first exception (address error, delay slot)
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h0000_1004; exc_bd = 1'b1;
    exc_badvaddr = 32'h0000_0123;
    tick(); exc_valid = 1'b0; #1;
    check("exc1_epc", epc_out, 32'h0000_1000);
    check("exc1_cause", cause_out, 32'h8000_0010);
    check("exc1_badv", cp0_reg_read, 32'h0000_0123);
    check("exc1_status", status_out, 32'h1000_0002);

    // nested exception: EPC/BD frozen, code updates, BadVAddr untouched
    exc_valid = 1'b1; exc_code = 5'd10; exc_pc = 32'h0000_2000; exc_bd = 1'b0;
    exc_badvaddr = 32'h0000_0456;
    tick(); exc_valid = 1'b0; #1;
    check("exc2_epc", epc_out, 32'h0000_1000);
    check("exc2_cause", cause_out, 32'h8000_0028);
    check("exc2_badv", cp0_reg_read, 32'h0000_0123);

    eret = 1'b1; tick(); eret = 1'b0; #1;
    check("eret_status", status_out, 32'h1000_0000);

    // interrupt pending
    do_write(5'd12, 32'h1000_0401);
    int_i = 6'b000001; #1;
    check("intp_before", {31'd0, int_pending}, 32'd0);
    tick();
    check("intp_after", {31'd0, int_pending}, 32'd1);
    check("cause_ip2", cause_out, 32'h8000_0428);
    do_write(5'd12, 32'h1000_0403);
    check("intp_exl", {31'd0, int_pending}, 32'd0);
    eret = 1'b1; tick(); eret = 1'b0; #1;
    check("eret_restore_st", status_out, 32'h1000_0401);
    check("eret_restore_ip", {31'd0, int_pending}, 32'd1);

    // priority: exception + eret + Status write
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h0000_3000; exc_bd = 1'b0; eret = 1'b1;
    cp0_reg_rw = 1'b1; cp0_reg_write_addr = 5'd12; cp0_reg_write = 32'h0000_0000;
    tick(); exc_valid = 1'b0; eret = 1'b0; cp0_reg_rw = 1'b0; #1;
    check("prio_status", status_out, 32'h1000_0002);
    check("prio_epc", epc_out, 32'h0000_3000);
    check("prio_cause", cause_out, 32'h0000_0400);

    // priority: eret beats software EXL set, IE still commits
    eret = 1'b1; cp0_reg_rw = 1'b1; cp0_reg_write_addr = 5'd12; cp0_reg_write = 32'h1000_0003;
    tick(); eret = 1'b0; cp0_reg_rw = 1'b0; #1;
    check("eret_vs_sw", status_out, 32'h1000_0001);

    // EPC wrap
    exc_valid = 1'b1; exc_pc = 32'h0000_0000; exc_bd = 1'b1;
    tick(); exc_valid = 1'b0; exc_bd = 1'b0; #1;
    check("epc_wrap", epc_out, 32'hFFFF_FFFC);
    eret = 1'b1; tick(); eret = 1'b0; #1;

    // EPC software write with forwarding
    cp0_reg_rw = 1'b1; cp0_reg_write_addr = 5'd14; cp0_reg_write = 32'h1234_5678;
    cp0_reg_read_addr = 5'd14; #1;
    check("epc_fwd", cp0_reg_read, 32'h1234_5678);
    check("epc_out_unfwd", epc_out, 32'hFFFF_FFFC);
    tick(); cp0_reg_rw = 1'b0; #1;
    check("epc_wr", epc_out, 32'h1234_5678);
    int_i = 6'd0;

`ifdef CP0_TIMER_EN
    do_write(5'd9, 32'h0000_0000);
    do_write(5'd11, 32'h0000_000A);
    check("timer_clear0", {31'd0, timer_int}, 32'd0);
    cp0_reg_read_addr = 5'd9;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (timer_int) found = 1'b1;
    end
    check("timer_set", {31'd0, timer_int}, 32'd1);
    check("count_at_match", cp0_reg_read, 32'd11);
    check("cause_ip7", {31'd0, cause_out[15]}, 32'd1);
    do_write(5'd11, 32'h0000_0014);
    check("timer_cleared", {31'd0, timer_int}, 32'd0);
`else
    found = 1'b0;
    cp0_reg_read_addr = 5'd9; do_write(5'd9, 32'h0000_AAAA);
    tick();
    check("count_off", cp0_reg_read, 32'h0000_0000);
    cp0_reg_read_addr = 5'd11; do_write(5'd11, 32'h0000_0005);
    check("compare_off", cp0_reg_read, 32'h0000_0000);
    check("timer_off", {31'd0, timer_int}, 32'd0);
`endif

    // exception + Status write in one cycle: EXL comes from the exception
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h0000_4000;
    cp0_reg_rw = 1'b1; cp0_reg_write_addr = 5'd12; cp0_reg_write = 32'h0000_0000;
    tick(); exc_valid = 1'b0; cp0_reg_rw = 1'b0; #1;
    check("exc_sw_status", status_out, 32'h1000_0002);
    check("exc_sw_epc", epc_out, 32'h0000_4000);

    // reset in the middle of an EPC write
    cp0_reg_rw = 1'b1; cp0_reg_write_addr = 5'd14; cp0_reg_write = 32'hDEAD_BEEF;
    #2; rst_n = 1'b0; #1;
    check("rst_mid_epc", epc_out, 32'h0000_0000);
    check("rst_mid_status", status_out, 32'h1000_0000);
    tick();
    check("rst_hold_epc", epc_out, 32'h0000_0000);
    cp0_reg_rw = 1'b0; rst_n = 1'b1; #1;
    do_write(5'd14, 32'h0000_00AA);
    check("post_rst_wr", epc_out, 32'h0000_00AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
